// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: parses a UART byte stream into RGB frames, stores them in a
// double-buffered pixel memory and feeds one pixel at a time to the WS2812B driver.
// Optional feature macro: CHECKSUM_EN (XOR checksum byte after the payload).
module uart_pixel_loader #(
  parameter int unsigned N_LEDS      = 16,
  parameter int unsigned IDX_W       = 5,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic       i_clk,
  input  logic       rst_n,          // synchronous, active-high
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_frame_sync,
  input  logic       i_pixel_next,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_rx_busy,
  output logic       o_pending
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned ADDR_W = IDX_W + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    RX_R    = 3'd1,
    RX_G    = 3'd2,
    RX_B    = 3'd3,
    RX_CSUM = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              pending_q, pending_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              active_q, active_d;
  logic              shown_q, shown_d;
  logic [23:0]       pix_q;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              sof_c;
  logic              in_rx_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [23:0]       mem_wdata_c;

  logic [23:0]       mem_q [2*DEPTH];

  // Parser FSM, timeout, bank swap and read pointer next-state logic
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_ptr_d    = rd_ptr_q;
    r_d         = r_q;
    g_d         = g_q;
    to_cnt_d    = '0;
    pending_d   = pending_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    active_d    = active_q;
    shown_d     = shown_q;
    sof_c       = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = {~active_q, wr_idx_q};
    mem_wdata_c = {r_q, g_q, i_rx_data};
    in_rx_c     = (state_q == RX_R) || (state_q == RX_G) ||
                  (state_q == RX_B) || (state_q == RX_CSUM);
`ifdef CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      HUNT: begin
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          sof_c    = 1'b1;
          wr_idx_d = '0;
`ifdef CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = RX_R;
        end
      end
      RX_R: begin
        if (i_rx_valid) begin
          r_d     = i_rx_data;
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ i_rx_data;
`endif
          state_d = RX_G;
        end
      end
      RX_G: begin
        if (i_rx_valid) begin
          g_d     = i_rx_data;
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ i_rx_data;
`endif
          state_d = RX_B;
        end
      end
      RX_B: begin
        if (i_rx_valid) begin
          mem_we_c = 1'b1;
          wr_idx_d = wr_idx_q + IDX_W'(1);
`ifdef CHECKSUM_EN
          csum_d   = csum_q ^ i_rx_data;
`endif
          if (wr_idx_q == IDX_W'(N_LEDS - 1)) begin
`ifdef CHECKSUM_EN
            state_d = RX_CSUM;
`else
            state_d = COMMIT;
`endif
          end else begin
            state_d = RX_R;
          end
        end
      end
`ifdef CHECKSUM_EN
      RX_CSUM: begin
        if (i_rx_valid) begin
          if (i_rx_data == csum_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
`endif
      COMMIT: begin
        ok_d    = 1'b1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    // Inter-byte idle timeout; the pulse coincides with the counter reaching TIMEOUT_CYC-1
    if (in_rx_c) begin
      if (i_rx_valid) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 2)) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    // A new frame start abandons any pending frame, since its bank is about to be overwritten
    if (sof_c) begin
      pending_d = 1'b0;
    end else if (state_q == COMMIT) begin
      pending_d = 1'b1;
    end else if (i_frame_sync && pending_q) begin
      pending_d = 1'b0;
      active_d  = ~active_q;
      shown_d   = 1'b1;
    end

    // Sync has priority over pixel stepping
    if (i_frame_sync) begin
      rd_ptr_d = '0;
    end else if (i_pixel_next) begin
      rd_ptr_d = (rd_ptr_q == IDX_W'(N_LEDS - 1)) ? '0 : rd_ptr_q + IDX_W'(1);
    end

    busy_d = (state_d != HUNT);
  end

  // Control and status registers
  always_ff @(posedge i_clk) begin
    if (rst_n) begin
      state_q   <= HUNT;
      wr_idx_q  <= '0;
      rd_ptr_q  <= '0;
      r_q       <= '0;
      g_q       <= '0;
      to_cnt_q  <= '0;
      pending_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      shown_q   <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_ptr_q  <= rd_ptr_d;
      r_q       <= r_d;
      g_q       <= g_d;
      to_cnt_q  <= to_cnt_d;
      pending_q <= pending_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
      shown_q   <= shown_d;
`ifdef CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Pixel memory write port (contents are not reset)
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Registered pixel read from the next-cycle pointer so outputs follow a pulse by one cycle
  always_ff @(posedge i_clk) begin
    if (rst_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= shown_d ? mem_q[{active_d, rd_ptr_d}] : '0;
    end
  end

  assign o_red       = pix_q[23:16];
  assign o_green     = pix_q[15:8];
  assign o_blue      = pix_q[7:0];
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_rx_busy   = busy_q;
  assign o_pending   = pending_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader against a frame-level display model.
module tb_uart_pixel_loader;

  localparam int unsigned N  = 16;
  localparam int unsigned TO = 300;
  localparam logic [7:0]  SB = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       pixel_next = 1'b0;
  logic [7:0] red, green, blue;
  logic       frame_ok, frame_err, rx_busy, pending;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;

  // Model: what is on screen, what is waiting, where the driver is
  logic [23:0] disp_m [N];
  logic [23:0] pend_m [N];
  logic [23:0] frame_buf [N];
  bit          pend_valid_m = 1'b0;
  bit          shown_m = 1'b0;
  int          rd_m = 0;

  uart_pixel_loader #(
    .N_LEDS(N), .IDX_W(5), .SYNC_BYTE(SB), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .rst_n(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_frame_sync(frame_sync), .i_pixel_next(pixel_next),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_frame_ok(frame_ok), .o_frame_err(frame_err),
    .o_rx_busy(rx_busy), .o_pending(pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] exp_pix();
    return shown_m ? disp_m[rd_m] : 24'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends frame_buf; returns right after the final byte's clock edge (the COMMIT cycle)
  task automatic send_frame(input bit bad_csum);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(SB);
    pend_valid_m = 1'b0;
    for (int k = 0; k < N; k++) begin
      send_byte(frame_buf[k][23:16]);
      send_byte(frame_buf[k][15:8]);
      send_byte(frame_buf[k][7:0]);
      cs = cs ^ frame_buf[k][23:16] ^ frame_buf[k][15:8] ^ frame_buf[k][7:0];
    end
`ifdef CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h01) : cs);
`else
    if (bad_csum) cs = ~cs;
`endif
  endtask

  task automatic commit_model();
    for (int k = 0; k < N; k++) pend_m[k] = frame_buf[k];
    pend_valid_m = 1'b1;
  endtask

  // From the COMMIT cycle: expect a single o_frame_ok pulse and o_pending rising
  task automatic finish_commit(input string tag);
    tick();
    commit_model();
    n_tests++;
    if ({frame_ok, pending} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_commit: ok/pending got %b want 11", tag, {frame_ok, pending});
    end
    tick();
    n_tests++;
    if (frame_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ok_single: frame_ok got %b want 0", tag, frame_ok);
    end
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    if (pend_valid_m) begin
      for (int k = 0; k < N; k++) disp_m[k] = pend_m[k];
      shown_m = 1'b1;
      pend_valid_m = 1'b0;
    end
    rd_m = 0;
  endtask

  task automatic pulse_next();
    pixel_next = 1'b1;
    tick();
    pixel_next = 1'b0;
    rd_m = (rd_m + 1) % N;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) frame_buf[k] = 24'($urandom);
    frame_buf[3] = {SB, SB, SB};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({red, green, blue, frame_ok, frame_err, rx_busy, pending} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {red, green, blue, frame_ok, frame_err, rx_busy, pending});
    end
    rst = 1'b0;
    tick();
    shown_m = 1'b0; rd_m = 0; pend_valid_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_next();
      n_tests++;
      if ({red, green, blue, pending} !== {exp_pix(), 1'b0}) begin
        n_fail++;
        $display("FAIL reset_next%0d: pix/pending got %h/%b want 0/0", i, {red, green, blue}, pending);
      end
    end
  endtask

  task automatic test_frame();
    int ok0;
    ok0 = ok_cnt;
    for (int k = 0; k < N; k++) frame_buf[k] = {8'(k), 8'(k + 16), 8'(k + 32)};
    send_frame(1'b0);
    finish_commit("frame");
    pulse_sync();
    n_tests++;
    if ({pending, red, green, blue} !== {1'b0, 24'h001020}) begin
      n_fail++;
      $display("FAIL frame_sync: pending/pix got %b/%h want 0/001020", pending, {red, green, blue});
    end
    for (int i = 1; i <= N; i++) begin
      pulse_next();
      n_tests++;
      if ({red, green, blue} !== exp_pix()) begin
        n_fail++;
        $display("FAIL frame_step%0d: pix got %h want %h", i, {red, green, blue}, exp_pix());
      end
    end
    n_tests++;
    if (ok_cnt - ok0 !== 1) begin
      n_fail++;
      $display("FAIL frame_ok_count: got %0d want 1", ok_cnt - ok0);
    end
  endtask

  task automatic test_bad_csum();
`ifdef CHECKSUM_EN
    int ok0;
    ok0 = ok_cnt;
    fill_random();
    send_frame(1'b1);
    n_tests++;
    if ({frame_err, rx_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL csum_err: err/busy got %b want 10", {frame_err, rx_busy});
    end
    tick();
    tick();
    n_tests++;
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_pending: got %b want 0", pending);
    end
    pulse_sync();
    n_tests++;
    if ({red, green, blue} !== exp_pix()) begin
      n_fail++;
      $display("FAIL csum_display: pix got %h want %h", {red, green, blue}, exp_pix());
    end
    n_tests++;
    if (ok_cnt !== ok0) begin
      n_fail++;
      $display("FAIL csum_no_ok: ok pulses got %0d want 0", ok_cnt - ok0);
    end
`endif
  endtask

  task automatic test_timeout();
    int err0;
    send_byte(SB);
    pend_valid_m = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    err0 = err_cnt;
    for (int m = 1; m <= int'(TO) - 1; m++) begin
      tick();
      n_tests++;
      if (m < int'(TO) - 1) begin
        if ({frame_err, rx_busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL timeout_early%0d: err/busy got %b want 01", m, {frame_err, rx_busy});
        end
      end else if ({frame_err, rx_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL timeout_fire: err/busy got %b want 10", {frame_err, rx_busy});
      end
    end
    tick();
    n_tests++;
    if ((err_cnt - err0 !== 1) || (pending !== 1'b0)) begin
      n_fail++;
      $display("FAIL timeout_once: err pulses/pending got %0d/%b want 1/0", err_cnt - err0, pending);
    end
    fill_random();
    send_frame(1'b0);
    finish_commit("after_timeout");
    pulse_sync();
    n_tests++;
    if ({red, green, blue} !== exp_pix()) begin
      n_fail++;
      $display("FAIL timeout_next_frame: pix got %h want %h", {red, green, blue}, exp_pix());
    end
  endtask

  task automatic test_midstrip();
    repeat (5) pulse_next();
    fill_random();
    send_frame(1'b0);
    finish_commit("midstrip");
    n_tests++;
    if ({red, green, blue} !== exp_pix()) begin
      n_fail++;
      $display("FAIL midstrip_old: pix got %h want %h", {red, green, blue}, exp_pix());
    end
    for (int i = 0; i < 3; i++) begin
      pulse_next();
      n_tests++;
      if ({red, green, blue} !== exp_pix()) begin
        n_fail++;
        $display("FAIL midstrip_step%0d: pix got %h want %h", i, {red, green, blue}, exp_pix());
      end
    end
    frame_sync = 1'b1;
    pixel_next = 1'b1;
    tick();
    frame_sync = 1'b0;
    pixel_next = 1'b0;
    for (int k = 0; k < N; k++) disp_m[k] = pend_m[k];
    pend_valid_m = 1'b0;
    rd_m = 0;
    n_tests++;
    if ({pending, red, green, blue} !== {1'b0, frame_buf[0]}) begin
      n_fail++;
      $display("FAIL midstrip_swap: pending/pix got %b/%h want 0/%h", pending, {red, green, blue}, frame_buf[0]);
    end
    pulse_next();
    n_tests++;
    if ({red, green, blue} !== frame_buf[1]) begin
      n_fail++;
      $display("FAIL midstrip_new1: pix got %h want %h", {red, green, blue}, frame_buf[1]);
    end
  endtask

  task automatic test_sync_in_commit();
    repeat (4) pulse_next();
    fill_random();
    send_frame(1'b0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    rd_m = 0;
    commit_model();
    n_tests++;
    if ({frame_ok, pending, red, green, blue} !== {2'b11, exp_pix()}) begin
      n_fail++;
      $display("FAIL commit_sync_deferred: ok/pending/pix got %b%b/%h want 11/%h",
               frame_ok, pending, {red, green, blue}, exp_pix());
    end
    tick();
    pulse_sync();
    n_tests++;
    if ({pending, red, green, blue} !== {1'b0, frame_buf[0]}) begin
      n_fail++;
      $display("FAIL commit_sync_later: pending/pix got %b/%h want 0/%h", pending, {red, green, blue}, frame_buf[0]);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(SB);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    shown_m = 1'b0; rd_m = 0; pend_valid_m = 1'b0;
    n_tests++;
    if ({rx_busy, pending, red, green, blue} !== {2'b00, exp_pix()}) begin
      n_fail++;
      $display("FAIL rst_mid: busy/pending/pix got %b%b/%h want 00/0", rx_busy, pending, {red, green, blue});
    end
    fill_random();
    send_frame(1'b0);
    finish_commit("rst_mid");
    pulse_sync();
    pulse_next();
    n_tests++;
    if ({red, green, blue} !== frame_buf[1]) begin
      n_fail++;
      $display("FAIL rst_mid_frame: pix got %h want %h", {red, green, blue}, frame_buf[1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_csum();
    test_timeout();
    test_midstrip();
    test_sync_in_commit();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
